// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse key tokenizer.
// Durations are expressed in Morse units and scaled by UNIT_CYCLES in the top.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2,
        ST_ERROR = 2'd3
    } morse_state_e;

    localparam int DASH_UNITS  = 2;
    localparam int LG_UNITS    = 3;
    localparam int WG_UNITS    = 7;
    localparam int STUCK_UNITS = 8;

endpackage

// File: rtl/morse_dur_counter.sv
// Saturating duration counter; clear and enable together load the value 1,
// so a new interval can start counting on the same edge that begins it.
module morse_dur_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] base_s;
    logic [CNT_W-1:0] next_s;

    // Select the start value and apply a saturating increment.
    always_comb begin
        base_s = clr ? {CNT_W{1'b0}} : count_r;
        next_s = base_s;
        if (en && !(&base_s)) begin
            next_s = base_s + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            next_s = base_s;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        count_r <= next_s;
    end

    assign count = count_r;

endmodule

// File: rtl/morse_key_tokenizer.sv
// Turns a synchronous Morse key level into Dot/Dash/letter-gap/word-gap pulses.
// Optional macro MORSE_KEY_GLITCH_FILTER_EN drops presses shorter than MIN_PRESS.
module morse_key_tokenizer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int CNT_W       = 16,
    parameter int MIN_PRESS   = 2
) (
    input  logic clock,
    input  logic Clr,
    input  logic Key,
    output logic Dot,
    output logic Dash,
    output logic Lg,
    output logic Wg,
    output logic Valid
);

    localparam logic [CNT_W-1:0] DASH_TH  = CNT_W'(DASH_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LG_TH    = CNT_W'(LG_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WG_TH    = CNT_W'(WG_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] STUCK_TH = CNT_W'(STUCK_UNITS * UNIT_CYCLES);
`ifdef MORSE_KEY_GLITCH_FILTER_EN
    localparam logic [CNT_W-1:0] MIN_TH   = CNT_W'(MIN_PRESS);
`endif

    morse_state_e     state_r, state_next;
    logic [CNT_W-1:0] n_r, g_r;
    logic [CNT_W:0]   g_inc_s;
    logic             n_clr_s, n_en_s, g_clr_s, g_en_s;
    logic             dot_r, dash_r, lg_r, wg_r, valid_r;
    logic             dot_next, dash_next, lg_next, wg_next, valid_next;
    logic             lg_sent_r, lg_sent_next;
    logic             from_gap_r, from_gap_next;
    logic             gap_lg_s, gap_wg_s;

    morse_dur_counter #(.CNT_W(CNT_W)) n_cnt (
        .clock (clock),
        .clr   (Clr | n_clr_s),
        .en    (~Clr & n_en_s),
        .count (n_r)
    );

    morse_dur_counter #(.CNT_W(CNT_W)) g_cnt (
        .clock (clock),
        .clr   (Clr | g_clr_s),
        .en    (~Clr & g_en_s),
        .count (g_r)
    );

    // Gap milestones; >= with a sent flag keeps Lg-then-Wg order even if G jumps past a threshold.
    always_comb begin
        g_inc_s  = {1'b0, g_r} + (CNT_W+1)'(1);
        gap_lg_s = !lg_sent_r && (g_inc_s >= {1'b0, LG_TH});
        gap_wg_s = lg_sent_r && (g_inc_s >= {1'b0, WG_TH});
    end

    // Next-state, counter control and pulse decode.
    always_comb begin
        state_next    = state_r;
        n_clr_s       = 1'b0;
        n_en_s        = 1'b0;
        g_clr_s       = 1'b0;
        g_en_s        = 1'b0;
        dot_next      = 1'b0;
        dash_next     = 1'b0;
        lg_next       = 1'b0;
        wg_next       = 1'b0;
        valid_next    = valid_r;
        lg_sent_next  = lg_sent_r;
        from_gap_next = from_gap_r;
        case (state_r)
            ST_IDLE: begin
                g_clr_s = 1'b1;
                if (Key) begin
                    state_next    = ST_PRESS;
                    n_clr_s       = 1'b1;
                    n_en_s        = 1'b1;
                    from_gap_next = 1'b0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_PRESS: begin
                if (Key) begin
                    n_en_s = 1'b1;
`ifdef MORSE_KEY_GLITCH_FILTER_EN
                    g_en_s = from_gap_r;
`endif
                    if (n_r == STUCK_TH - CNT_W'(1)) begin
                        state_next = ST_ERROR;
                        valid_next = 1'b0;
                    end else begin
                        state_next = ST_PRESS;
                    end
                end else begin
`ifdef MORSE_KEY_GLITCH_FILTER_EN
                    if (n_r < MIN_TH) begin
                        if (from_gap_r) begin
                            g_en_s       = 1'b1;
                            lg_next      = gap_lg_s;
                            wg_next      = gap_wg_s;
                            lg_sent_next = lg_sent_r | gap_lg_s;
                            state_next   = gap_wg_s ? ST_IDLE : ST_GAP;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        dot_next     = (n_r < DASH_TH);
                        dash_next    = (n_r >= DASH_TH);
                        g_clr_s      = 1'b1;
                        g_en_s       = 1'b1;
                        lg_sent_next = 1'b0;
                        state_next   = ST_GAP;
                    end
`else
                    dot_next     = (n_r < DASH_TH);
                    dash_next    = (n_r >= DASH_TH);
                    g_clr_s      = 1'b1;
                    g_en_s       = 1'b1;
                    lg_sent_next = 1'b0;
                    state_next   = ST_GAP;
`endif
                end
            end
            ST_GAP: begin
                if (Key) begin
                    state_next    = ST_PRESS;
                    n_clr_s       = 1'b1;
                    n_en_s        = 1'b1;
                    from_gap_next = 1'b1;
`ifdef MORSE_KEY_GLITCH_FILTER_EN
                    g_en_s        = 1'b1;
`endif
                end else begin
                    g_en_s       = 1'b1;
                    lg_next      = gap_lg_s;
                    wg_next      = gap_wg_s;
                    lg_sent_next = lg_sent_r | gap_lg_s;
                    state_next   = gap_wg_s ? ST_IDLE : ST_GAP;
                end
            end
            ST_ERROR: begin
                valid_next = 1'b0;
                state_next = ST_ERROR;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; Clr wins over everything.
    always_ff @(posedge clock) begin
        if (Clr) begin
            state_r    <= ST_IDLE;
            dot_r      <= 1'b0;
            dash_r     <= 1'b0;
            lg_r       <= 1'b0;
            wg_r       <= 1'b0;
            valid_r    <= 1'b1;
            lg_sent_r  <= 1'b0;
            from_gap_r <= 1'b0;
        end else begin
            state_r    <= state_next;
            dot_r      <= dot_next;
            dash_r     <= dash_next;
            lg_r       <= lg_next;
            wg_r       <= wg_next;
            valid_r    <= valid_next;
            lg_sent_r  <= lg_sent_next;
            from_gap_r <= from_gap_next;
        end
    end

    assign Dot   = dot_r;
    assign Dash  = dash_r;
    assign Lg    = lg_r;
    assign Wg    = wg_r;
    assign Valid = valid_r;

endmodule

// File: tb/tb_morse_key_tokenizer.sv
// Directed bench for morse_key_tokenizer at UNIT_CYCLES=4.
// Pulse vectors are {Dot, Dash, Lg, Wg}; expectations are hand-computed.
module tb_morse_key_tokenizer;

    logic clock = 1'b0;
    logic Clr   = 1'b1;
    logic Key   = 1'b0;
    logic Dot, Dash, Lg, Wg, Valid;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] acc;
    logic       vall;
    logic       vany;

    always #5 clock = ~clock;

    morse_key_tokenizer #(
        .UNIT_CYCLES (4),
        .CNT_W       (16),
        .MIN_PRESS   (2)
    ) dut (
        .clock (clock),
        .Clr   (Clr),
        .Key   (Key),
        .Dot   (Dot),
        .Dash  (Dash),
        .Lg    (Lg),
        .Wg    (Wg),
        .Valid (Valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive Key on the falling edge, observe just after the rising edge.
    task automatic tick(input logic k);
        @(negedge clock);
        Key = k;
        @(posedge clock);
        #1;
    endtask

    task automatic hold(input logic k, input int n);
        acc  = 4'b0000;
        vall = 1'b1;
        vany = 1'b0;
        repeat (n) begin
            tick(k);
            acc  = acc | {Dot, Dash, Lg, Wg};
            vall = vall & Valid;
            vany = vany | Valid;
        end
    endtask

    task automatic do_clr(input logic k);
        @(negedge clock);
        Clr = 1'b1;
        Key = k;
        @(posedge clock);
        #1;
        Clr = 1'b0;
    endtask

    initial begin
        do_clr(1'b0);
        do_clr(1'b0);
        check_eq("reset_pulses", {Dot, Dash, Lg, Wg}, 4'b0000);
        check_eq("reset_valid", Valid, 1'b1);

        // Dot with full gap timing
        hold(1'b1, 4);   check_eq("a_press_quiet", acc, 4'b0000);
        tick(1'b0);      check_eq("a_dot", {Dot, Dash, Lg, Wg}, 4'b1000);
        hold(1'b0, 10);  check_eq("a_pre_lg", acc, 4'b0000);
        tick(1'b0);      check_eq("a_lg_at_11", {Dot, Dash, Lg, Wg}, 4'b0010);
        hold(1'b0, 15);  check_eq("a_pre_wg", acc, 4'b0000);
        check_eq("a_valid", vall, 1'b1);
        tick(1'b0);      check_eq("a_wg_at_27", {Dot, Dash, Lg, Wg}, 4'b0001);
        hold(1'b0, 40);  check_eq("idle_quiet", acc, 4'b0000);

        // Dash and classification boundaries
        hold(1'b1, 12);  check_eq("b_press12_quiet", acc, 4'b0000);
        tick(1'b0);      check_eq("b_dash12", {Dot, Dash, Lg, Wg}, 4'b0100);
        hold(1'b0, 2);
        hold(1'b1, 7);
        tick(1'b0);      check_eq("b_dot7", {Dot, Dash, Lg, Wg}, 4'b1000);
        hold(1'b0, 2);
        hold(1'b1, 8);
        tick(1'b0);      check_eq("b_dash8", {Dot, Dash, Lg, Wg}, 4'b0100);

        // 11-cycle gap gives no Lg; 12-cycle gap gives Lg only
        hold(1'b0, 10);  check_eq("c_gap11_no_lg", acc, 4'b0000);
        hold(1'b1, 4);   check_eq("c_press_no_lg", acc, 4'b0000);
        tick(1'b0);      check_eq("c_dot", {Dot, Dash, Lg, Wg}, 4'b1000);
        hold(1'b0, 11);  check_eq("c_gap12_lg_only", acc, 4'b0010);
        hold(1'b1, 3);   check_eq("c_press_no_wg", acc, 4'b0000);
        tick(1'b0);      check_eq("c_dot2", {Dot, Dash, Lg, Wg}, 4'b1000);
        hold(1'b0, 30);  check_eq("c_long_gap", acc, 4'b0011);

        // One-cycle press inside a gap
        hold(1'b1, 4);
        tick(1'b0);      check_eq("d_dot", {Dot, Dash, Lg, Wg}, 4'b1000);
        hold(1'b0, 4);
        hold(1'b1, 1);   check_eq("d_glitch_press", acc, 4'b0000);
`ifdef MORSE_KEY_GLITCH_FILTER_EN
        tick(1'b0);      check_eq("d_glitch_dropped", {Dot, Dash, Lg, Wg}, 4'b0000);
        hold(1'b0, 4);   check_eq("d_pre_lg", acc, 4'b0000);
        tick(1'b0);      check_eq("d_lg_unchanged", {Dot, Dash, Lg, Wg}, 4'b0010);
`else
        tick(1'b0);      check_eq("d_glitch_dot", {Dot, Dash, Lg, Wg}, 4'b1000);
        hold(1'b0, 10);  check_eq("d_pre_lg", acc, 4'b0000);
        tick(1'b0);      check_eq("d_lg", {Dot, Dash, Lg, Wg}, 4'b0010);
`endif
        hold(1'b0, 20);  check_eq("d_wg", acc, 4'b0001);

        // Stuck key
        do_clr(1'b0);
        hold(1'b1, 31);  check_eq("e_pre_stuck_quiet", acc, 4'b0000);
        check_eq("e_pre_stuck_valid", vall, 1'b1);
        tick(1'b1);      check_eq("e_valid_fall", Valid, 1'b0);
        check_eq("e_no_pulse_stuck", {Dot, Dash, Lg, Wg}, 4'b0000);
        hold(1'b1, 8);
        tick(1'b0);      check_eq("e_no_dash", {Dot, Dash, Lg, Wg}, 4'b0000);
        hold(1'b1, 4);
        hold(1'b0, 30);  check_eq("e_error_quiet", acc, 4'b0000);
        check_eq("e_valid_stays_low", vany, 1'b0);
        do_clr(1'b0);    check_eq("e_clr_valid", Valid, 1'b1);
        check_eq("e_clr_pulses", {Dot, Dash, Lg, Wg}, 4'b0000);
        hold(1'b0, 40);  check_eq("e_idle_quiet", acc, 4'b0000);
        hold(1'b1, 4);
        tick(1'b0);      check_eq("e_dot_after_clr", {Dot, Dash, Lg, Wg}, 4'b1000);

        // Clr mid-press, key still held
        hold(1'b0, 30);
        hold(1'b1, 6);
        do_clr(1'b1);    check_eq("f_clr_pulses", {Dot, Dash, Lg, Wg}, 4'b0000);
        check_eq("f_clr_valid", Valid, 1'b1);
        hold(1'b1, 6);   check_eq("f_press_quiet", acc, 4'b0000);
        tick(1'b0);      check_eq("f_dot_n6", {Dot, Dash, Lg, Wg}, 4'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_key_tokenizer.md
MORSE_KEY_TOKENIZER -- requirements
Module: morse_key_tokenizer

Interface
REQ-001 Parameter UNIT_CYCLES, default 4, clock cycles per Morse time unit; legal range 1..(2^CNT_W-1)/8.
REQ-002 Parameter CNT_W, default 16, width of the duration counter.
REQ-003 Parameter MIN_PRESS, default 2, shortest accepted press in cycles; used only with the glitch filter.
REQ-004 Port clock  input  1  single clock; every flop updates on its rising edge.
REQ-005 Port Clr  input  1  reset; synchronous, active-high.
REQ-006 Port Key  input  1  key level, 1=pressed; already synchronous to clock.
REQ-007 Port Dot  output  1  one-cycle pulse: dot element completed.
REQ-008 Port Dash  output  1  one-cycle pulse: dash element completed.
REQ-009 Port Lg  output  1  one-cycle pulse: letter gap (3 units) reached.
REQ-010 Port Wg  output  1  one-cycle pulse: word gap (7 units) reached.
REQ-011 Port Valid  output  1  level: 1 while the token stream is good; 0 after a stuck key.
REQ-012 All outputs SHALL be registered; Dot, Dash, Lg and Wg SHALL be mutually exclusive in every cycle.

Function
REQ-013 The FSM SHALL have states IDLE, PRESS, GAP and ERROR.
REQ-014 IDLE: on a Key=1 sample go to PRESS with press count N=1; otherwise stay, with no pulses.
REQ-015 PRESS: each Key=1 sample increments N; the counter saturates at 2^CNT_W-1.
REQ-016 PRESS: the first Key=0 sample ends the press and classifies it.
  - N < 2*UNIT_CYCLES: assert Dot on that edge.
  - 2*UNIT_CYCLES <= N < 8*UNIT_CYCLES: assert Dash on that edge.
  - In both cases go to GAP with gap count G=1.
REQ-017 PRESS: on the edge where N reaches 8*UNIT_CYCLES, go to ERROR and drive Valid to 0 on that edge; emit no Dot or Dash.
REQ-018 GAP: each Key=0 sample increments G.
  - Assert Lg on the edge where G becomes 3*UNIT_CYCLES.
  - Assert Wg on the edge where G becomes 7*UNIT_CYCLES, then go to IDLE.
REQ-019 GAP: a Key=1 sample goes to PRESS with N=1; any Lg/Wg not yet emitted is dropped.
REQ-020 Order: a gap of 7 or more units SHALL produce exactly Lg then Wg, once each; IDLE SHALL never emit Lg or Wg.
REQ-021 ERROR: ignore Key, keep all pulses at 0 and Valid at 0 until Clr.
REQ-022 Latency: a Dot or Dash pulse SHALL appear on the same edge that samples the release; Lg and Wg as in REQ-018.

Reset
REQ-023 Clr SHALL take priority over all other inputs.
REQ-024 On Clr: state=IDLE, N=0, G=0; Dot, Dash, Lg and Wg = 0; Valid = 1.
REQ-025 Clr during PRESS or GAP SHALL discard the element or gap in progress with no pulse.
REQ-026 A Key still held after Clr releases SHALL be timed as a new press from N=1.

Configuration
REQ-027 Macro MORSE_KEY_GLITCH_FILTER_EN.
  - Defined: a press ending with N < MIN_PRESS SHALL be discarded with no pulse.
    - Press began in GAP: return to GAP; G SHALL continue counting from its pre-press value plus the press cycles.
    - Press began in IDLE: return to IDLE.
  - Undefined: every press with N >= 1 SHALL be classified per REQ-016, and MIN_PRESS SHALL be unused.

Structure
REQ-028 Shared package morse_pkg SHALL hold:
  - the state enum;
  - constants DASH_UNITS=2, LG_UNITS=3, WG_UNITS=7, STUCK_UNITS=8.
REQ-029 One sub-module, morse_dur_counter, SHALL provide the CNT_W-bit saturating counter with clear and enable; it is instantiated for N and G, or once and shared.

Verification (UNIT_CYCLES=4)
REQ-030 Key=1 for 4 cycles, then 0 -> Dot high for 1 cycle on the release-sample edge; Lg 11 edges later; Wg 27 edges after Dot; Valid=1 throughout.
REQ-031 Key=1 for 12 cycles -> Dash pulse; Key=1 for 7 cycles -> Dot (boundary); Key=1 for 8 cycles -> Dash (boundary).
REQ-032 Dot, then Key=0 for 11 cycles, then Key=1 -> no Lg; Key=0 for 12 cycles -> Lg only, no Wg.
REQ-033 Key=1 for 40 cycles -> Valid falls on the 32nd sample; no Dash on release; further presses produce no pulses; Clr -> Valid=1 and state IDLE.
REQ-034 With MORSE_KEY_GLITCH_FILTER_EN: a 1-cycle press inside a gap -> no pulse, Lg timing unchanged. Without the macro: the same stimulus -> Dot.
REQ-035 Clr asserted mid-press at N=6 with Key held 6 more cycles -> one Dot (N=6 counted from 1 after Clr); no pulse from the discarded press.
